// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the sequential binary-to-BCD converter.
//   - bcd_state_e : converter FSM states
//   - BcdDigitW   : bits per BCD digit
//   - min_digits(): smallest digit count with 10^d > 2^width
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } bcd_state_e;

    localparam int unsigned BcdDigitW = 4;

    // 2^width is never a power of ten, so the minimum d is floor(width*log10(2)) + 1.
    function automatic int unsigned min_digits(input int unsigned width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational double-dabble iteration.
// Adds 3 to every BCD digit >= 5, then shifts the whole {digits, binary} vector left by one.
//   vec_i : {DIGITS BCD digits, WIDTH binary bits} before the iteration
//   vec_o : same vector after add-3 correction and 1-bit left shift
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic [BcdDigitW*DIGITS+WIDTH-1:0] vec_i,
    output logic [BcdDigitW*DIGITS+WIDTH-1:0] vec_o
);

    localparam int unsigned TotW = BcdDigitW * DIGITS + WIDTH;

    logic [TotW-1:0] corr;

    always_comb begin
        corr = vec_i;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (corr[WIDTH+BcdDigitW*i +: BcdDigitW] >= 4'd5) begin
                corr[WIDTH+BcdDigitW*i +: BcdDigitW] =
                    corr[WIDTH+BcdDigitW*i +: BcdDigitW] + 4'd3;
            end
        end
        vec_o = {corr[TotW-2:0], 1'b0};
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential binary-to-BCD converter, one double-dabble iteration per clock.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request a conversion, accepted only while ready=1
//   binary     : value to convert, sampled on the accepting edge
//   ready      : idle, able to accept start
//   valid      : one-cycle pulse once bcd/sign/num_digits carry a new result
//   bcd        : packed BCD result, units digit in [3:0]
//   sign       : input was negative (SIGNED builds only)
//   num_digits : significant digits, 1..DIGITS
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [WIDTH-1:0]                 binary,
    output logic                             ready,
    output logic                             valid,
    output logic [BcdDigitW*DIGITS-1:0]      bcd,
    output logic                             sign,
    output logic [$clog2(DIGITS+1)-1:0]      num_digits
);

    localparam int unsigned TotW = BcdDigitW * DIGITS + WIDTH;
    localparam int unsigned BcdW = BcdDigitW * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned NdW  = $clog2(DIGITS + 1);

    if (DIGITS < min_digits(WIDTH)) begin : gen_digits_check
        $error("bcd_seq_converter: DIGITS too small for WIDTH");
    end

    bcd_state_e      state_q, state_d;
    logic [TotW-1:0] shift_q, shift_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [BcdW-1:0] bcd_q, bcd_d;
    logic            sign_q, sign_d;
    logic [NdW-1:0]  ndig_q, ndig_d;

    logic [TotW-1:0]  step_out;
    logic [NdW-1:0]   ndig_calc;
    logic             in_neg;
    logic [WIDTH-1:0] in_mag;

    bcd_dabble_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .vec_i (shift_q),
        .vec_o (step_out)
    );

    // Negation in WIDTH bits maps the most negative value onto its correct magnitude.
    always_comb begin
        in_neg = SIGNED && binary[WIDTH-1];
        in_mag = in_neg ? (~binary + WIDTH'(1)) : binary;
    end

    // Highest nonzero digit of the final iteration's result.
    always_comb begin
        ndig_calc = NdW'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (step_out[WIDTH+BcdDigitW*i +: BcdDigitW] != '0) begin
                ndig_calc = NdW'(i + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        ready_d = ready_q;
        valid_d = valid_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        ndig_d  = ndig_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    neg_d   = in_neg;
                    shift_d = {{BcdW{1'b0}}, in_mag};
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                shift_d = step_out;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    bcd_d   = step_out[TotW-1 -: BcdW];
                    sign_d  = neg_q;
                    ndig_d  = ndig_calc;
                    valid_d = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            ndig_q  <= NdW'(1);
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            ndig_q  <= ndig_d;
        end
    end

    assign ready      = ready_q;
    assign valid      = valid_q;
    assign bcd        = bcd_q;
    assign sign       = sign_q;
    assign num_digits = ndig_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
`timescale 1ns/1ps
module tb_bcd_seq_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [15:0] binary = '0;
    logic        ready, valid, sign;
    logic [19:0] bcd;
    logic [2:0]  num_digits;

    logic        start8 = 1'b0;
    logic [7:0]  binary8 = '0;
    logic        ready8, valid8, sign8;
    logic [11:0] bcd8;
    logic [1:0]  num_digits8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_seq_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .binary     (binary),
        .ready      (ready),
        .valid      (valid),
        .bcd        (bcd),
        .sign       (sign),
        .num_digits (num_digits)
    );

    bcd_seq_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .binary     (binary8),
        .ready      (ready8),
        .valid      (valid8),
        .bcd        (bcd8),
        .sign       (sign8),
        .num_digits (num_digits8)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Start one conversion on the 16-bit DUT; cyc = posedges from accepting edge to valid.
    task automatic conv16(input logic [15:0] v, output int cyc);
        @(negedge clk);
        start  = 1'b1;
        binary = v;
        @(posedge clk);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            if (valid) break;
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 100) check("conv16_timeout", 32'(cyc), 32'd16);
    endtask

    task automatic conv8(input logic [7:0] v, output int cyc);
        @(negedge clk);
        start8  = 1'b1;
        binary8 = v;
        @(posedge clk);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            start8 = 1'b0;
            if (valid8) break;
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 100) check("conv8_timeout", 32'(cyc), 32'd8);
    endtask

    initial begin
        int cyc;
        int pulses;
        int vtimes[$];
        logic [19:0] last_bcd;
        logic [11:0] ref_bcd;
        logic [1:0]  ref_nd;

        // Reset values
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_sign", 32'(sign), 32'd0);
        check("rst_ndig", 32'(num_digits), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 12345: latency, result, ready timing
        conv16(16'd12345, cyc);
        check("lat_12345", 32'(cyc), 32'd16);
        check("bcd_12345", 32'(bcd), 32'h12345);
        check("sign_12345", 32'(sign), 32'd0);
        check("ndig_12345", 32'(num_digits), 32'd5);
        check("ready_during_valid", 32'(ready), 32'd0);
        @(negedge clk);
        check("ready_after", 32'(ready), 32'd1);
        check("valid_one_cycle", 32'(valid), 32'd0);

        conv16(16'h8000, cyc);
        check("bcd_m32768", 32'(bcd), 32'h32768);
        check("sign_m32768", 32'(sign), 32'd1);
        check("ndig_m32768", 32'(num_digits), 32'd5);

        conv16(16'hFFFF, cyc);
        check("bcd_m1", 32'(bcd), 32'h00001);
        check("sign_m1", 32'(sign), 32'd1);
        check("ndig_m1", 32'(num_digits), 32'd1);

        conv16(16'd0, cyc);
        check("bcd_0", 32'(bcd), 32'h0);
        check("sign_0", 32'(sign), 32'd0);
        check("ndig_0", 32'(num_digits), 32'd1);

        conv16(16'd32767, cyc);
        check("bcd_32767", 32'(bcd), 32'h32767);
        check("sign_32767", 32'(sign), 32'd0);

        // start during a conversion is dropped
        @(negedge clk);
        @(negedge clk);
        start  = 1'b1;
        binary = 16'd42;
        pulses = 0;
        last_bcd = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (c == 5) begin
                start  = 1'b1;
                binary = 16'd999;
            end
            if (c == 6) start = 1'b0;
            if (c == 8) binary = 16'd777;
            if (valid) begin
                pulses++;
                last_bcd = bcd;
            end
        end
        check("busy_pulses", 32'(pulses), 32'd1);
        check("busy_bcd", 32'(last_bcd), 32'h00042);

        // start held high: back-to-back conversions
        @(negedge clk);
        start  = 1'b1;
        binary = 16'd7;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (valid) vtimes.push_back(c);
        end
        start = 1'b0;
        check("hold_count", 32'(vtimes.size()), 32'd3);
        if (vtimes.size() >= 3) begin
            check("hold_period1", 32'(vtimes[1] - vtimes[0]), 32'd18);
            check("hold_period2", 32'(vtimes[2] - vtimes[1]), 32'd18);
        end
        check("hold_bcd", 32'(bcd), 32'h00007);
        repeat (20) @(negedge clk);

        // Reset in the middle of a conversion
        @(negedge clk);
        start  = 1'b1;
        binary = 16'hFFF6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_bcd", 32'(bcd), 32'h0);
        check("mid_rst_sign", 32'(sign), 32'd0);
        check("mid_rst_ndig", 32'(num_digits), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        check("mid_rst_no_valid", 32'(pulses), 32'd0);

        conv16(16'd500, cyc);
        check("bcd_500", 32'(bcd), 32'h00500);
        check("ndig_500", 32'(num_digits), 32'd3);

        // 8-bit unsigned instance
        conv8(8'd255, cyc);
        check("lat8_255", 32'(cyc), 32'd8);
        check("bcd8_255", 32'(bcd8), 32'h255);
        check("sign8_255", 32'(sign8), 32'd0);

        for (int v = 0; v < 256; v++) begin
            ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            ref_nd  = (v >= 100) ? 2'd3 : (v >= 10) ? 2'd2 : 2'd1;
            conv8(8'(v), cyc);
            check($sformatf("sweep8_bcd_%0d", v), 32'(bcd8), 32'(ref_bcd));
            check($sformatf("sweep8_nd_%0d", v), 32'(num_digits8), 32'(ref_nd));
        end
        check("sign8_final", 32'(sign8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_seq_converter.md
# bcd_seq_converter

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one iteration per clock. Replaces the fully unrolled combinational converter on wide or timing-critical paths: it accepts a signed or unsigned word via a start/ready handshake and returns packed BCD digits, a sign flag and a significant-digit count. It sits between the arithmetic datapath and the seven-segment/display driver.

## Interface
- WIDTH, 16, input word width in bits (≥ 2)
- DIGITS, 5, BCD output digits; must satisfy 10^DIGITS > 2^WIDTH
- SIGNED, 1, 1 = input is two's complement; 0 = unsigned
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request conversion; accepted only when ready=1
- binary  input  WIDTH  value to convert; sampled only on the accepting edge
- ready  output  1  converter idle, can accept start
- valid  output  1  one-cycle pulse, result outputs updated
- bcd  output  4*DIGITS  packed result; digit 0 (units) in bits [3:0]
- sign  output  1  1 = input was negative (always 0 when SIGNED=0)
- num_digits  output  clog2(DIGITS+1)  significant digits, 1..DIGITS (value 0 reports 1)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: ready=1. start=1 at an edge → latch sign and magnitude, clear digit register, counter=0, go SHIFT.
- Magnitude: SIGNED=1 and binary MSB=1 → two's-complement negation, held in WIDTH unsigned bits (most negative value, e.g. −32768, yields 32768 correctly). Otherwise binary unchanged.
- SHIFT: each cycle, every digit ≥5 gets +3, then {digits, magnitude} shifts left by 1; counter increments. Iteration WIDTH−1 also writes bcd, sign, num_digits and goes DONE.
- num_digits = index of highest nonzero digit + 1; 1 when all digits are zero.
- DONE: valid=1 for exactly one cycle, then IDLE.
- bcd/sign/num_digits hold the last result until the next completion; never change mid-conversion.
- start while ready=0: ignored, not queued. binary changes after acceptance: ignored.
- start held high continuously: a new conversion is accepted on each return to IDLE.

## Timing
- Reset (asynchronous): state IDLE, ready=1, valid=0, bcd=0, sign=0, num_digits=1, counter=0, internal registers cleared. Reset mid-conversion aborts it; no valid is produced.
- Accepting edge E0. Iterations at E1..E_WIDTH; outputs updated at E_WIDTH; valid=1 in the cycle after E_WIDTH; IDLE again at E_WIDTH+1.
- ready is low from E0 until E_WIDTH+1.
- Latency: WIDTH cycles from the accepting edge to valid. Throughput: one conversion per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package bcd_pkg: FSM state enum (IDLE/SHIFT/DONE), BCD digit width constant (4), and a constant function for the minimum number of digits given WIDTH, used for parameter checking.
- One sub-module, bcd_dabble_step: combinational single iteration (add-3 correction on DIGITS digits, then 1-bit left shift) over a {4*DIGITS + WIDTH}-bit vector.
- Elaboration check: fail if DIGITS is below the bcd_pkg minimum.

## Test plan
- Defaults, binary=12345 → valid exactly 16 cycles after the accepting edge; bcd=0x12345, sign=0, num_digits=5; ready high again one cycle later.
- binary=−32768 (0x8000) → bcd=0x32768, sign=1. binary=−1 → bcd=0x00001, sign=1, num_digits=1.
- binary=0 → bcd=0x00000, sign=0, num_digits=1. binary=32767 → bcd=0x32767.
- Pulse start=1 with binary=999 mid-conversion of 42 → only one valid pulse, with bcd=0x00042. Hold start high with a fixed value → valid every 18 cycles.
- Assert rst at iteration 7 → all outputs take their reset values immediately, no valid. A later conversion of 500 → bcd=0x00500, num_digits=3.
- WIDTH=8, DIGITS=3, SIGNED=0: binary=255 → bcd=0x255, sign=0, valid 8 cycles after acceptance. Sweep all 256 inputs against a reference model.
